// File: rtl/fast_axis_tx_if.sv
// Bundles the FAST UM upstream beat bus and the downstream AXI-Stream bus.
// The master side drives beats in and sinks the stream; the slave side is the TX bridge.
interface fast_axis_tx_if;
  logic [255:0] pktout_data;
  logic         pktout_data_wr;
  logic         pktout_data_valid_wr;
  logic         pktout_data_valid;
  logic [31:0]  tx_axis_tkeep_int_3;
  logic [1:0]   tx_axis_tuser_int_3;
  logic         pktout_ready;

  logic [255:0] tx_axis_tdata_fast;
  logic [31:0]  tx_axis_tkeep_fast;
  logic [127:0] tx_axis_tuser_fast;
  logic         tx_axis_tlast_fast;
  logic         tx_axis_tvalid_fast;
  logic         tx_axis_tready_fast;

  modport master (
    output pktout_data, pktout_data_wr, pktout_data_valid_wr, pktout_data_valid,
           tx_axis_tkeep_int_3, tx_axis_tuser_int_3, tx_axis_tready_fast,
    input  pktout_ready, tx_axis_tdata_fast, tx_axis_tkeep_fast, tx_axis_tuser_fast,
           tx_axis_tlast_fast, tx_axis_tvalid_fast
  );

  modport slave (
    input  pktout_data, pktout_data_wr, pktout_data_valid_wr, pktout_data_valid,
           tx_axis_tkeep_int_3, tx_axis_tuser_int_3, tx_axis_tready_fast,
    output pktout_ready, tx_axis_tdata_fast, tx_axis_tkeep_fast, tx_axis_tuser_fast,
           tx_axis_tlast_fast, tx_axis_tvalid_fast
  );
endinterface

// File: rtl/fast_axis_tx.sv
// FAST UM to AXI-Stream TX bridge: beat FIFO with whole-packet drop, error marking
// for truncated packets, and registered upstream flow control.
module fast_axis_tx #(
  parameter PLATFORM = "Xilinx",
  parameter int DEPTH = 16,
  parameter int AFULL = 3
) (
  input  logic         clk,
  input  logic         rst,
  fast_axis_tx_if.slave bus,
  output logic [15:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] NONLAST_LIM = CW'(DEPTH - 2);
  localparam logic [CW-1:0] LAST_LIM    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] READY_LIM   = CW'(DEPTH - AFULL);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || PLATFORM == "") begin : g_param_check
    $error("fast_axis_tx: DEPTH must be a power of two >= 4 and PLATFORM non-empty");
  end

  typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic [1:0]   user;
    logic         last;
    logic         err;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt, cnt_next;
  state_t          state, state_next;
  logic            err_pend, err_pend_next;
  logic            push, push_last, push_err, drop, pop;
  logic            is_last, accept;
  entry_t          head;

  assign is_last = bus.pktout_data_wr & bus.pktout_data_valid_wr;
  // Non-last beats leave one slot free so a packet's last beat always fits.
  assign accept  = is_last ? (cnt <= LAST_LIM) : (cnt <= NONLAST_LIM);
  assign pop     = (cnt != '0) & bus.tx_axis_tready_fast;

  always_comb begin
    state_next    = state;
    err_pend_next = err_pend;
    push          = 1'b0;
    push_last     = 1'b0;
    push_err      = 1'b0;
    drop          = 1'b0;
    if (bus.pktout_data_wr) begin
      case (state)
        IDLE: begin
          if (accept) begin
            push      = 1'b1;
            push_last = is_last;
            push_err  = is_last & ~bus.pktout_data_valid;
            if (!is_last) state_next = PKT;
          end else begin
            drop = 1'b1;
            if (!is_last) state_next = DROP;
          end
        end
        PKT: begin
          if (is_last) begin
            push          = 1'b1;
            push_last     = 1'b1;
            push_err      = err_pend | ~bus.pktout_data_valid;
            err_pend_next = 1'b0;
            state_next    = IDLE;
          end else if (accept) begin
            push = 1'b1;
          end else begin
            err_pend_next = 1'b1;
          end
        end
        DROP: begin
          if (is_last) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_next = cnt;
    if (push && !pop)      cnt_next = cnt + CW'(1);
    else if (!push && pop) cnt_next = cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{data: bus.pktout_data, keep: bus.tx_axis_tkeep_int_3,
                       user: bus.tx_axis_tuser_int_3, last: push_last, err: push_err};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      cnt              <= '0;
      err_pend         <= 1'b0;
      drop_cnt         <= '0;
      bus.pktout_ready <= 1'b0;
    end else begin
      state            <= state_next;
      err_pend         <= err_pend_next;
      cnt              <= cnt_next;
      bus.pktout_ready <= (cnt_next < READY_LIM);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign head                    = mem[rd_ptr];
  assign bus.tx_axis_tvalid_fast = (cnt != '0);
  assign bus.tx_axis_tdata_fast  = head.data;
  assign bus.tx_axis_tkeep_fast  = head.keep;
  assign bus.tx_axis_tuser_fast  = {125'd0, head.err, head.user};
  assign bus.tx_axis_tlast_fast  = head.last;

endmodule

// File: tb/tb_fast_axis_tx.sv
// Directed bench for fast_axis_tx: a per-cycle vector table for the basic
// packet shapes plus hand-written fill/drop, flow-control and reset sequences.
module tb_fast_axis_tx;

  logic        clk;
  logic        rst;
  logic [15:0] drop_cnt;
  int          errors = 0;
  int          checks = 0;

  fast_axis_tx_if bus ();

  fast_axis_tx #(.PLATFORM("Xilinx"), .DEPTH(16), .AFULL(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        wr, vwr, vld, rdy;
    logic [7:0]  tag;
    logic [31:0] keep;
    logic [1:0]  user;
    logic        ev, el, ee;
    logic [7:0]  etag;
    logic [31:0] ekeep;
    logic [1:0]  euser;
  } vec_t;

  vec_t vecs [15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic vwr, input logic vld, input logic rdy,
                       input logic [7:0] tag, input logic [31:0] keep, input logic [1:0] user);
    bus.pktout_data          = {32{tag}};
    bus.pktout_data_wr       = wr;
    bus.pktout_data_valid_wr = vwr;
    bus.pktout_data_valid    = vld;
    bus.tx_axis_tkeep_int_3  = keep;
    bus.tx_axis_tuser_int_3  = user;
    bus.tx_axis_tready_fast  = rdy;
  endtask

  task automatic applyStimulus(input vec_t v);
    drive(v.wr, v.vwr, v.vld, v.rdy, v.tag, v.keep, v.user);
  endtask

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkHead(input string name, input logic [7:0] tag, input logic last,
                           input logic err);
    checkOutput({name, " tvalid"}, bus.tx_axis_tvalid_fast, 1'b1);
    checkOutput({name, " tdata"}, bus.tx_axis_tdata_fast, {32{tag}});
    checkOutput({name, " tlast"}, bus.tx_axis_tlast_fast, last);
    checkOutput({name, " err"}, bus.tx_axis_tuser_fast[2], err);
  endtask

  initial begin
    int n;

    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA1, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, 1'b0, 8'hA1, 32'hFFFFFFFF, 2'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hA2, 32'hFFFFFFFF, 2'd2, 1'b1, 1'b0, 1'b0, 8'hA2, 32'hFFFFFFFF, 2'd2};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hA3, 32'h0000FFFF, 2'd3, 1'b1, 1'b1, 1'b0, 8'hA3, 32'h0000FFFF, 2'd3};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hB1, 32'h0000000F, 2'd0, 1'b1, 1'b1, 1'b1, 8'hB1, 32'h0000000F, 2'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hC1, 32'h000000FF, 2'd2, 1'b1, 1'b1, 1'b0, 8'hC1, 32'h000000FF, 2'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hC2, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'hD1, 32'hFFFFFFFF, 2'd1, 1'b1, 1'b0, 1'b0, 8'hD1, 32'hFFFFFFFF, 2'd1};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 8'hD2, 32'h00FFFFFF, 2'd1, 1'b1, 1'b1, 1'b1, 8'hD2, 32'h00FFFFFF, 2'd1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'hE1, 32'hFFFFFFFF, 2'd3, 1'b1, 1'b0, 1'b0, 8'hE1, 32'hFFFFFFFF, 2'd3};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0, 1'b1, 1'b0, 1'b0, 8'hE1, 32'hFFFFFFFF, 2'd3};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'hE2, 32'h0000FF00, 2'd2, 1'b1, 1'b1, 1'b0, 8'hE2, 32'h0000FF00, 2'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0,        2'd0};

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 2'd0);
    repeat (3) step();
    checkOutput("reset pktout_ready", bus.pktout_ready, 1'b0);
    checkOutput("reset tvalid", bus.tx_axis_tvalid_fast, 1'b0);
    checkOutput("reset drop_cnt", drop_cnt, 16'd0);
    rst = 1'b0;
    step();
    checkOutput("ready after reset", bus.pktout_ready, 1'b1);

    // Each row is applied before an edge and its expectations hold just after it.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("row%0d tvalid", i), bus.tx_axis_tvalid_fast, vecs[i].ev);
      checkOutput($sformatf("row%0d ready", i), bus.pktout_ready, 1'b1);
      if (vecs[i].ev) begin
        checkOutput($sformatf("row%0d tdata", i), bus.tx_axis_tdata_fast, {32{vecs[i].etag}});
        checkOutput($sformatf("row%0d tkeep", i), bus.tx_axis_tkeep_fast, vecs[i].ekeep);
        checkOutput($sformatf("row%0d tuser", i), bus.tx_axis_tuser_fast,
                    {125'd0, vecs[i].ee, vecs[i].euser});
        checkOutput($sformatf("row%0d tlast", i), bus.tx_axis_tlast_fast, vecs[i].el);
      end
    end
    checkOutput("table drop_cnt", drop_cnt, 16'd0);

    // Fill with tready=0: 15 non-last beats fit, 5 are cut, the last beat takes the final slot.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'(i), 32'hFFFFFFFF, 2'(i));
      step();
      if (i == 11) checkOutput("ready at cnt12", bus.pktout_ready, 1'b1);
      if (i == 12) checkOutput("ready at cnt13", bus.pktout_ready, 1'b0);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, 32'hFFFFFFFF, 2'd0);
    step();
    checkOutput("fill drop_cnt", drop_cnt, 16'd0);
    checkOutput("fill cnt", dut.cnt, 5'd16);

    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 32'hFFFFFFFF, 2'd0);
    step();
    checkOutput("full first beat drop_cnt", drop_cnt, 16'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hF1, 32'hFFFFFFFF, 2'd0);
    step();
    checkOutput("full last beat drop_cnt", drop_cnt, 16'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 2'd0);
    step();
    checkHead("held head", 8'h00, 1'b0, 1'b0);

    bus.tx_axis_tready_fast = 1'b1;
    n = 0;
    while (bus.tx_axis_tvalid_fast && n < 40) begin
      if (n < 15) checkHead($sformatf("drain beat%0d", n), 8'(n), 1'b0, 1'b0);
      else        checkHead($sformatf("drain beat%0d", n), 8'hEE, 1'b1, 1'b1);
      step();
      n++;
      if (n == 3) checkOutput("ready at cnt13 draining", bus.pktout_ready, 1'b0);
      if (n == 4) checkOutput("ready at cnt12 draining", bus.pktout_ready, 1'b1);
    end
    checkOutput("drain beat count", 32'(n), 32'd16);

    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 32'hFFFFFFFF, 2'd1);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 2'd0);
    checkHead("post-drop packet", 8'h5A, 1'b1, 1'b0);
    checkOutput("post-drop drop_cnt", drop_cnt, 16'd1);
    step();
    checkOutput("post-drop empty", bus.tx_axis_tvalid_fast, 1'b0);

    // Reset in the middle of a buffered packet.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i), 32'hFFFFFFFF, 2'd0);
      step();
    end
    checkOutput("mid-packet tvalid", bus.tx_axis_tvalid_fast, 1'b1);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h70, 32'hFFFFFFFF, 2'd0);
    step();
    checkOutput("mid rst tvalid", bus.tx_axis_tvalid_fast, 1'b0);
    checkOutput("mid rst ready", bus.pktout_ready, 1'b0);
    checkOutput("mid rst drop_cnt", drop_cnt, 16'd0);
    checkOutput("mid rst cnt", dut.cnt, 5'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 2'd0);
    step();
    checkOutput("held rst ready", bus.pktout_ready, 1'b0);
    rst = 1'b0;
    step();
    checkOutput("ready after mid rst", bus.pktout_ready, 1'b1);
    checkOutput("tvalid after mid rst", bus.tx_axis_tvalid_fast, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h7A, 32'h0000FFFF, 2'd2);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0, 2'd0);
    checkHead("first packet after rst", 8'h7A, 1'b1, 1'b0);
    step();
    checkOutput("empty after first packet", bus.tx_axis_tvalid_fast, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
